eth_txarb_nch: RTL and testbench
================================

ETH_TXARB_NCH -- requirements
Module: eth_txarb_nch

Interface
REQ-001 SHALL have parameter NCH, default 4, number of input FIFO channels (2..8).
REQ-002 SHALL have parameter DW, default 81, input beat width: [63:0] data, [71:64] keep, [72] last, [80:73] user.
REQ-003 SHALL have parameter LAST_BIT, default 72, bit index of the last flag in a beat.
REQ-004 SHALL have parameter CHW, default 2, channel-id width; 2**CHW >= NCH required.
REQ-005 SHALL have parameter MODE, default 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
REQ-006 SHALL have parameter MAX_BEATS, default 512, packet length limit in beats (>= 2).
REQ-007 clk  in  1  single clock for all logic (clk156 domain).
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 fifo_empty  in  NCH  per-channel input FIFO empty.
REQ-010 fifo_dout  in  NCH*DW  per-channel FWFT head beat; channel i at [i*DW +: DW].
REQ-011 fifo_rd_en  out  NCH  per-channel pop.
REQ-012 full  in  1  output FIFO full.
REQ-013 wr_en  out  1  output FIFO write.
REQ-014 din  out  DW+CHW  output beat {channel id, beat}.
REQ-015 grant  out  CHW  currently granted channel.
REQ-016 busy  out  1  high in XFER or DROP.
REQ-017 err_trunc  out  1  one-cycle pulse on forced truncation.

Function
REQ-018 SHALL implement states IDLE, XFER, DROP.
REQ-019 IDLE: when any fifo_empty[i]==0, SHALL latch grant and enter XFER next cycle; no pops in IDLE (1-cycle arbitration latency).
REQ-020 MODE=1: SHALL search from rr_ptr upward, wrapping NCH-1 -> 0; first non-empty wins.
REQ-021 MODE=0: SHALL grant lowest-index non-empty channel.
REQ-022 XFER: fifo_rd_en[grant] = wr_en = !fifo_empty[grant] && !full, combinational; all other rd_en bits 0.
REQ-023 din SHALL equal {grant, fifo_dout[grant]}, with last bit overridden per REQ-026.
REQ-024 SHALL count accepted beats per packet in a counter of $clog2(MAX_BEATS)+1 bits, cleared on entry to XFER.
REQ-025 Beat accepted with last=1 SHALL return to IDLE; rr_ptr <= (grant+1) mod NCH.
REQ-026 Accepted beat MAX_BEATS with last=0: SHALL force din last bit to 1, pulse err_trunc same cycle, enter DROP.
REQ-027 DROP: fifo_rd_en[grant] = !fifo_empty[grant] (ignores full), wr_en=0; on popped beat with last=1 SHALL return to IDLE and advance rr_ptr as REQ-025.
REQ-028 Granted channel empty mid-packet: SHALL hold grant and state, no pop/write, until data returns (no channel switching mid-packet).
REQ-029 full and empty simultaneous: stall, no pop, no write.
REQ-030 Beat MAX_BEATS arriving with last=1: normal end, no err_trunc.
REQ-031 busy = (state != IDLE); grant holds last value in IDLE.

Reset
REQ-032 rst SHALL force state IDLE, rr_ptr 0, grant 0, beat counter 0, err_trunc 0; fifo_rd_en and wr_en 0 in the same cycle rst is high.
REQ-033 rst mid-packet SHALL abandon the packet with no further pops or writes; next grant follows REQ-020/021 from rr_ptr 0.

Verification
REQ-034 NCH=4, MODE=1, all channels hold 2-beat packets -> grants 0,1,2,3,0 in order; din[82:81] matches channel each beat.
REQ-035 MODE=0, channels 1 and 3 non-empty continuously -> channel 1 granted every packet, channel 3 starved.
REQ-036 full asserted 3 cycles mid-packet -> wr_en and rd_en 0 for exactly those cycles, no beat lost or duplicated.
REQ-037 MAX_BEATS=4, 6-beat packet on channel 2 -> 4 beats written, beat 4 last=1, err_trunc one pulse, beats 5-6 popped not written, IDLE after beat 6.
REQ-038 rst pulsed at beat 2 of 5-beat packet on channel 1 -> outputs 0 during rst, then grant restarts search at channel 0.
REQ-039 Channel 0 empties after beat 1 of 3 while channel 1 non-empty -> grant stays 0, no writes until channel 0 refills, then beats 2-3 complete.

Source files
------------

// File: rtl/eth_txarb_nch.sv
// Packet-level arbiter: merges NCH FWFT input FIFOs into one output FIFO,
// tags each beat with its channel and truncates packets longer than MAX_BEATS.
module eth_txarb_nch #(
    parameter int NCH       = 4,
    parameter int DW        = 81,
    parameter int LAST_BIT  = 72,
    parameter int CHW       = 2,
    parameter int MODE      = 1,
    parameter int MAX_BEATS = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      fifo_empty,
    input  logic [NCH*DW-1:0]   fifo_dout,
    output logic [NCH-1:0]      fifo_rd_en,
    input  logic                full,
    output logic                wr_en,
    output logic [DW+CHW-1:0]   din,
    output logic [CHW-1:0]      grant,
    output logic                busy,
    output logic                err_trunc,
    output logic [1:0]          state_dbg
);
    localparam int CW = $clog2(MAX_BEATS) + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_DROP = 2'd2} state_t;

    state_t          state, state_nx;
    logic [CHW-1:0]  rr_ptr, rr_ptr_nx, grant_nx, sel, next_ptr;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            any_req, found, g_empty, head_last, pop;
    logic [DW-1:0]   head, beat_out;
    int              idx;

    assign head      = fifo_dout[int'(grant)*DW +: DW];
    assign head_last = head[LAST_BIT];
    assign g_empty   = fifo_empty[grant];
    assign any_req   = (fifo_empty != {NCH{1'b1}});
    assign next_ptr  = (grant == CHW'(NCH-1)) ? '0 : grant + 1'b1;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;
    assign din       = {grant, beat_out};

    // Channel selection: round-robin from rr_ptr, or lowest index first.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        if (MODE == 1) begin
            for (int i = 0; i < NCH; i++) begin
                idx = (int'(rr_ptr) + i) % NCH;
                if (!found && !fifo_empty[idx]) begin
                    sel   = CHW'(idx);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = NCH-1; i >= 0; i--) begin
                if (!fifo_empty[i]) sel = CHW'(i);
            end
        end
    end

    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        rr_ptr_nx  = rr_ptr;
        cnt_nx     = cnt;
        pop        = 1'b0;
        wr_en      = 1'b0;
        err_trunc  = 1'b0;
        beat_out   = head;
        fifo_rd_en = '0;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    grant_nx = sel;
                    cnt_nx   = '0;
                    state_nx = S_XFER;
                end
            end
            S_XFER: begin
                if (!g_empty && !full) begin
                    pop    = 1'b1;
                    wr_en  = 1'b1;
                    cnt_nx = cnt + 1'b1;
                    if (head_last) begin
                        state_nx  = S_IDLE;
                        rr_ptr_nx = next_ptr;
                    end else if (cnt == CW'(MAX_BEATS-1)) begin
                        // Close the packet downstream; the tail is discarded in DROP.
                        beat_out[LAST_BIT] = 1'b1;
                        err_trunc          = 1'b1;
                        state_nx           = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (!g_empty) begin
                    pop = 1'b1;
                    if (head_last) begin
                        state_nx  = S_IDLE;
                        rr_ptr_nx = next_ptr;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (rst) begin
            pop       = 1'b0;
            wr_en     = 1'b0;
            err_trunc = 1'b0;
        end
        fifo_rd_en[grant] = pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            rr_ptr <= rr_ptr_nx;
            grant  <= grant_nx;
            cnt    <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_eth_txarb_nch.sv
// Bench for eth_txarb_nch: a round-robin and a fixed-priority instance are fed
// from queue-modelled FIFOs and checked against a packet-level reference model.
module tb_eth_txarb_nch;
    localparam int NCH = 4, DW = 81, LAST_BIT = 72, CHW = 2, MAXB = 4;
    localparam int EW = DW + CHW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic full = 1'b0;
    logic [NCH-1:0]    fe   [2];
    logic [NCH*DW-1:0] fd   [2];
    logic [NCH-1:0]    rd   [2];
    logic              wr   [2];
    logic [DW+CHW-1:0] dout [2];
    logic [CHW-1:0]    gnt  [2];
    logic              bsy  [2];
    logic              et   [2];
    logic [1:0]        sdbg [2];

    logic [DW-1:0] fq [2*NCH][$];
    logic [DW-1:0] mq [2*NCH][$];
    logic [EW-1:0] exp_q [2][$];
    logic [NCH-1:0] rd_s [2];
    int mptr [2];
    int wr_cnt [2];
    int n_checks = 0, n_err = 0;
    int full_pct = 0, hide_pct = 0;
    logic full_force = 1'b0;

    always #5 clk = ~clk;

    eth_txarb_nch #(.NCH(NCH), .DW(DW), .LAST_BIT(LAST_BIT), .CHW(CHW), .MODE(1), .MAX_BEATS(MAXB)) u_rr (
        .clk(clk), .rst(rst), .fifo_empty(fe[0]), .fifo_dout(fd[0]), .fifo_rd_en(rd[0]), .full(full),
        .wr_en(wr[0]), .din(dout[0]), .grant(gnt[0]), .busy(bsy[0]), .err_trunc(et[0]), .state_dbg(sdbg[0]));

    eth_txarb_nch #(.NCH(NCH), .DW(DW), .LAST_BIT(LAST_BIT), .CHW(CHW), .MODE(0), .MAX_BEATS(MAXB)) u_fp (
        .clk(clk), .rst(rst), .fifo_empty(fe[1]), .fifo_dout(fd[1]), .fifo_rd_en(rd[1]), .full(full),
        .wr_en(wr[1]), .din(dout[1]), .grant(gnt[1]), .busy(bsy[1]), .err_trunc(et[1]), .state_dbg(sdbg[1]));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Driver: pop what the DUT took at the last edge, then present new heads.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++)
                if (rd_s[d][c] && fq[d*NCH+c].size() > 0) void'(fq[d*NCH+c].pop_front());
        end
        full = full_force || ($urandom_range(99) < full_pct);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                // Holes only while busy so arbitration sees true occupancy.
                fe[d][c] = (fq[d*NCH+c].size() == 0) || (bsy[d] && ($urandom_range(99) < hide_pct));
                fd[d][c*DW +: DW] = (fq[d*NCH+c].size() > 0) ? fq[d*NCH+c][0] : '0;
            end
        end
    end

    // Monitor: sample where the DUT will act, score every write.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            rd_s[d] = rd[d];
            chk("rd_on_empty", 128'(rd[d] & fe[d]), 128'(0));
            if (rst) begin
                chk("rst_rd", 128'(rd[d]), 128'(0));
                chk("rst_wr", 128'(wr[d]), 128'(0));
                chk("rst_trunc", 128'(et[d]), 128'(0));
            end
            if (et[d] && !wr[d]) chk("trunc_without_wr", 128'(et[d]), 128'(0));
            if (wr[d]) begin
                wr_cnt[d]++;
                chk("wr_while_full", 128'(full), 128'(0));
                chk("rd_match", 128'(rd[d]), 128'(NCH'(1) << gnt[d]));
                if (exp_q[d].size() == 0) chk("unexpected_wr", 128'({et[d], dout[d]}), 128'(0));
                else chk("din", 128'({et[d], dout[d]}), 128'(exp_q[d].pop_front()));
            end
        end
    end

    // Reference: whole packets in arbitration order, truncated at MAXB beats.
    task automatic model_run(input int d);
        int c, k;
        logic [DW-1:0] b;
        logic lst, tr;
        forever begin
            c = -1;
            if (d == 0) begin
                for (int i = 0; i < NCH; i++)
                    if (c < 0 && mq[d*NCH + (mptr[d]+i) % NCH].size() > 0) c = (mptr[d]+i) % NCH;
            end else begin
                for (int i = NCH-1; i >= 0; i--)
                    if (mq[d*NCH+i].size() > 0) c = i;
            end
            if (c < 0) break;
            k = 0;
            do begin
                b = mq[d*NCH+c].pop_front();
                k++;
                lst = b[LAST_BIT];
                if (k <= MAXB) begin
                    tr = (k == MAXB) && !lst;
                    if (tr) b[LAST_BIT] = 1'b1;
                    exp_q[d].push_back({tr, CHW'(c), b});
                end
            end while (!lst);
            mptr[d] = (c + 1) % NCH;
        end
    endtask

    task automatic add_pkt(input int c, input int len);
        logic [DW-1:0] b;
        for (int j = 0; j < len; j++) begin
            b = '0;
            b[31:0]  = $urandom();
            b[63:32] = $urandom();
            b[71:64] = 8'($urandom());
            b[80:73] = 8'($urandom());
            b[LAST_BIT] = (j == len-1);
            for (int d = 0; d < 2; d++) begin
                fq[d*NCH+c].push_back(b);
                mq[d*NCH+c].push_back(b);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        full_force = 1'b0;
        for (int i = 0; i < 2*NCH; i++) begin fq[i].delete(); mq[i].delete(); end
        for (int d = 0; d < 2; d++) begin exp_q[d].delete(); mptr[d] = 0; wr_cnt[d] = 0; end
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
    endtask

    function automatic logic all_done();
        logic ok;
        ok = !bsy[0] && !bsy[1] && exp_q[0].size() == 0 && exp_q[1].size() == 0;
        for (int i = 0; i < 2*NCH; i++) if (fq[i].size() != 0) ok = 1'b0;
        return ok;
    endfunction

    task automatic wait_done(input string name, input int bound);
        int cyc;
        cyc = 0;
        while (!all_done() && cyc < bound) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk(name, 128'(all_done()), 128'(1));
        for (int d = 0; d < 2; d++) chk("leftover_exp", 128'(exp_q[d].size()), 128'(0));
    endtask

    initial begin
        int cyc;
        for (int d = 0; d < 2; d++) begin fe[d] = '1; fd[d] = '0; rd_s[d] = '0; wr_cnt[d] = 0; mptr[d] = 0; end

        do_reset();
        for (int d = 0; d < 2; d++) begin
            chk("reset_grant", 128'(gnt[d]), 128'(0));
            chk("reset_busy", 128'(bsy[d]), 128'(0));
            chk("reset_state", 128'(sdbg[d]), 128'(0));
        end

        // Every channel holds two 2-beat packets.
        do_reset();
        for (int r = 0; r < 2; r++) for (int c = 0; c < NCH; c++) add_pkt(c, 2);
        model_run(0); model_run(1);
        wait_done("rr_all_channels", 2000);

        // Channels 1 and 3 only: fixed priority drains channel 1 first.
        do_reset();
        full_pct = 20;
        for (int r = 0; r < 3; r++) begin add_pkt(1, 3); add_pkt(3, 2); end
        model_run(0); model_run(1);
        wait_done("ch1_ch3", 2000);

        // Three cycles of full in the middle of a packet.
        do_reset();
        full_pct = 0; hide_pct = 0;
        add_pkt(0, 4);
        model_run(0); model_run(1);
        cyc = 0;
        while (wr_cnt[0] < 1 && cyc < 100) begin @(posedge clk); #2; cyc++; end
        chk("first_beat_seen", 128'(wr_cnt[0] >= 1), 128'(1));
        full_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("full_stall_wr", 128'(wr[0]), 128'(0));
            chk("full_stall_rd", 128'(rd[0]), 128'(0));
        end
        full_force = 1'b0;
        wait_done("full_stall", 500);

        // Oversized packet on channel 2 followed by a normal one on channel 3.
        do_reset();
        full_pct = 15;
        add_pkt(2, 6); add_pkt(3, 2); add_pkt(1, 4);
        model_run(0); model_run(1);
        wait_done("truncation", 1000);

        // Reset mid-packet: first move the pointer, then abandon a 5-beat packet.
        do_reset();
        full_pct = 0; hide_pct = 0;
        add_pkt(2, 1);
        model_run(0); model_run(1);
        wait_done("pre_reset_pkt", 500);
        add_pkt(1, 5); add_pkt(2, 2);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2*NCH; i++) mq[i].delete();
            exp_q[d].push_back({1'b0, CHW'(1), fq[d*NCH+1][0]});
            exp_q[d].push_back({1'b0, CHW'(1), fq[d*NCH+1][1]});
            wr_cnt[d] = 0;
        end
        cyc = 0;
        while ((wr_cnt[0] < 2 || wr_cnt[1] < 2) && cyc < 100) begin @(posedge clk); #2; cyc++; end
        chk("two_beats_before_rst", 128'(wr_cnt[0] == 2 && wr_cnt[1] == 2), 128'(1));
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_grant", 128'(gnt[d]), 128'(0));
            chk("midrst_busy", 128'(bsy[d]), 128'(0));
            chk("midrst_exp", 128'(exp_q[d].size()), 128'(0));
            mptr[d] = 0;
        end
        for (int i = 0; i < 2*NCH; i++) mq[i] = fq[i];
        add_pkt(3, 1);
        model_run(0); model_run(1);
        wait_done("after_mid_reset", 1000);

        // Randomized traffic with backpressure and empty holes.
        for (int p = 0; p < 8; p++) begin
            do_reset();
            full_pct = $urandom_range(0, 40);
            hide_pct = $urandom_range(0, 30);
            for (int n = $urandom_range(3, 10); n > 0; n--)
                add_pkt($urandom_range(0, NCH-1), $urandom_range(1, 6));
            model_run(0); model_run(1);
            wait_done("random_phase", 5000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
